// File: rtl/add_sub_seq.sv
// Digit-serial add/subtract unit: a 2-bit adder slice walks the operands LSB-first,
// two bits per cycle, with valid/ready handshakes on both the operand and result sides.
module add_sub_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o
);

  localparam int STEPS = WIDTH / 2;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if ((WIDTH < 2) || (WIDTH % 2 != 0)) begin : g_width_check
    $error("add_sub_seq: WIDTH must be even and >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [2:0]       slice_sum;
  logic [WIDTH-1:0] res_shifted;
  logic             last_step;

  assign slice_sum = {1'b0, a_sh_q[1:0]} + {1'b0, b_sh_q[1:0]} + {2'b00, carry_q};
  assign last_step = (cnt_q == CW'(STEPS - 1));

  // Result digits enter at the top so the first slice ends up in the LSBs.
  if (STEPS == 1) begin : g_res_single
    assign res_shifted = slice_sum[1:0];
  end else begin : g_res_multi
    assign res_shifted = {slice_sum[1:0], res_sh_q[WIDTH-1:2]};
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = (state_q == S_DONE);
  assign result_o    = result_q;
  assign cout_o      = cout_q;

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    result_d = result_q;
    carry_d  = carry_q;
    sub_d    = sub_q;
    cout_d   = cout_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          a_sh_d  = a_i;
          b_sh_d  = b_i ^ {WIDTH{sub_i}};
          carry_d = sub_i;
          sub_d   = sub_i;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        carry_d  = slice_sum[2];
        a_sh_d   = a_sh_q >> 2;
        b_sh_d   = b_sh_q >> 2;
        res_sh_d = res_shifted;
        cnt_d    = cnt_q + CW'(1);
        if (last_step) begin
          // Output copies are loaded once so they hold until the next completed op.
          result_d = res_shifted;
          cout_d   = slice_sum[2] ^ sub_q;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      sub_q    <= 1'b0;
      cout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      sub_q    <= sub_d;
      cout_q   <= cout_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule
